// File: rtl/qcpu_rom_fetch.sv
// Byte fetch engine for a SPI / quad-SPI serial flash, with read-stream continuation.
// Latency: SPI 81 / quad 45 cycles fresh, 17 / 5 sequential in HOLD, +2 after a deselect.
// Backpressure: a request is taken only while busy=0; requests made while busy are dropped.
//
// Ports: clk_i/rst_n (sync active-low); fetch_req/fetch_addr/quad_sel request a byte;
// fetch_data/fetch_valid return it; busy flags a fetch in flight; CS_ROM, SCLK_ROM,
// ROM_DO, ROM_DI, ROM_OEB and ROM_spi_mode form the flash pin interface.
// Optional feature: define QCPU_ROM_QUAD_EN to enable quad reads (0xEB); otherwise
// quad_sel is ignored and every fetch uses single-bit SPI read (0x03).

module qcpu_rom_fetch (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        quad_sel,
    output logic [7:0]  fetch_data,
    output logic        fetch_valid,
    output logic        busy,
    output logic        CS_ROM,
    output logic        SCLK_ROM,
    output logic [3:0]  ROM_DO,
    input  logic [3:0]  ROM_DI,
    output logic        ROM_OEB,
    output logic        ROM_spi_mode
);

    localparam logic [7:0] CMD_SPI  = 8'h03;
    localparam logic [7:0] CMD_QUAD = 8'hEB;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_HOLD, S_DESEL
`ifdef QCPU_ROM_QUAD_EN
        , S_DUMMY
`endif
    } state_t;

    state_t      state_q;
    logic        sclk_q;
    logic [4:0]  cnt_q;      // SCLK bits (or nibbles) left in the current phase, minus one
    logic [23:0] sh_q;       // outgoing command / address, MSB on the wire next
    logic [7:0]  dat_q;      // incoming data shift register
    logic [15:0] addr_q;     // address of the fetch in flight / last fetched
    logic [5:0]  hold_q;     // idle cycles spent in HOLD
    logic        cs_q;
    logic [3:0]  do_q;
    logic        oeb_q;
    logic        fv_q;
    logic        busy_q;
    logic [7:0]  fdata_q;
    logic        quad_q;
    logic        req_quad;

`ifdef QCPU_ROM_QUAD_EN
    logic spim_q;
    assign req_quad     = quad_sel;
    assign ROM_spi_mode = spim_q;
`else
    logic unused_quad_sel;
    assign unused_quad_sel = quad_sel;
    assign req_quad        = 1'b0;
    assign quad_q          = 1'b0;
    assign ROM_spi_mode    = 1'b1;
`endif

    logic       accept;
    logic       seq_hit;
    logic [7:0] cmd_now;
    logic [7:0] nxt_byte;
    logic [23:0] addr_word;

    assign accept   = fetch_req && !busy_q && (state_q == S_IDLE || state_q == S_HOLD);
    // 17-bit compare so 0xFFFF -> 0x0000 does not count as sequential
    assign seq_hit  = ({1'b0, fetch_addr} == ({1'b0, addr_q} + 17'd1)) && (req_quad == quad_q);
    // DESEL restarts with the mode already captured; IDLE uses the incoming request
    assign cmd_now  = ((state_q == S_DESEL) ? quad_q : req_quad) ? CMD_QUAD : CMD_SPI;
    assign nxt_byte = quad_q ? {dat_q[3:0], ROM_DI} : {dat_q[6:0], ROM_DI[1]};
    assign addr_word = {8'h00, addr_q};

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            dat_q   <= '0;
            addr_q  <= '0;
            hold_q  <= '0;
            cs_q    <= 1'b1;
            do_q    <= '0;
            oeb_q   <= 1'b1;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
            fdata_q <= '0;
`ifdef QCPU_ROM_QUAD_EN
            quad_q  <= 1'b0;
            spim_q  <= 1'b1;
`endif
        end else begin
            fv_q <= 1'b0;
            if (accept) begin
                addr_q <= fetch_addr;
`ifdef QCPU_ROM_QUAD_EN
                quad_q <= req_quad;
                spim_q <= !req_quad;
`endif
            end
            case (state_q)
                S_IDLE: begin
                    cs_q   <= 1'b1;
                    sclk_q <= 1'b0;
                    do_q   <= '0;
                    oeb_q  <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        busy_q  <= 1'b1;
                        state_q <= S_CMD;
                        cs_q    <= 1'b0;
                        oeb_q   <= 1'b0;
                        sh_q    <= {cmd_now, 16'h0000};
                        do_q    <= {3'b000, cmd_now[7]};
                        cnt_q   <= 5'd7;
                    end
                end
                S_HOLD: begin
                    // busy is still high during the fetch_valid cycle
                    busy_q <= 1'b0;
                    sclk_q <= 1'b0;
                    do_q   <= '0;
                    if (!busy_q) begin
                        if (accept) begin
                            busy_q <= 1'b1;
                            hold_q <= '0;
                            if (seq_hit) begin
                                // flash keeps streaming: just clock out the next byte
                                state_q <= S_DATA;
                                cnt_q   <= req_quad ? 5'd1 : 5'd7;
                                oeb_q   <= req_quad;
                            end else begin
                                state_q <= S_DESEL;
                                cs_q    <= 1'b1;
                                cnt_q   <= 5'd1;
                                oeb_q   <= 1'b1;
                            end
                        end else if (hold_q == 6'd63) begin
                            state_q <= S_IDLE;
                            cs_q    <= 1'b1;
                            oeb_q   <= 1'b1;
                            hold_q  <= '0;
                        end else begin
                            hold_q <= hold_q + 6'd1;
                        end
                    end
                end
                S_DESEL: begin
                    if (cnt_q == 5'd0) begin
                        state_q <= S_CMD;
                        cs_q    <= 1'b0;
                        oeb_q   <= 1'b0;
                        sh_q    <= {cmd_now, 16'h0000};
                        do_q    <= {3'b000, cmd_now[7]};
                        cnt_q   <= 5'd7;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                S_CMD: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_ADDR;
                            sh_q    <= addr_word;
                            do_q    <= quad_q ? addr_word[23:20] : {3'b000, addr_word[23]};
                            cnt_q   <= quad_q ? 5'd5 : 5'd23;
                        end else begin
                            sh_q  <= sh_q << 1;
                            do_q  <= {3'b000, sh_q[22]};
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        if (cnt_q == 5'd0) begin
                            do_q <= '0;
`ifdef QCPU_ROM_QUAD_EN
                            if (quad_q) begin
                                state_q <= S_DUMMY;
                                cnt_q   <= 5'd5;
                            end else
`endif
                            begin
                                state_q <= S_DATA;
                                cnt_q   <= 5'd7;
                            end
                        end else begin
                            sh_q  <= quad_q ? (sh_q << 4) : (sh_q << 1);
                            do_q  <= quad_q ? sh_q[19:16] : {3'b000, sh_q[22]};
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
`ifdef QCPU_ROM_QUAD_EN
                S_DUMMY: begin
                    // 2 SCLK of mode byte 0x00 still driven, then 4 SCLK turnaround
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        do_q   <= '0;
                        if (cnt_q == 5'd4) oeb_q <= 1'b1;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_DATA;
                            cnt_q   <= 5'd1;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        dat_q  <= nxt_byte;
                        if (cnt_q == 5'd0) begin
                            state_q <= S_HOLD;
                            fdata_q <= nxt_byte;
                            fv_q    <= 1'b1;
                            hold_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fetch_data  = fdata_q;
    assign fetch_valid = fv_q;
    assign busy        = busy_q;
    assign CS_ROM      = cs_q;
    assign SCLK_ROM    = sclk_q;
    assign ROM_DO      = do_q;
    assign ROM_OEB     = oeb_q;

endmodule

// File: tb/tb_qcpu_rom_fetch.sv
// Bench for qcpu_rom_fetch: directed fetches against a small serial-flash model.
module tb_qcpu_rom_fetch;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        quad_sel = 1'b0;
    logic [7:0]  fetch_data;
    logic        fetch_valid;
    logic        busy;
    logic        CS_ROM;
    logic        SCLK_ROM;
    logic [3:0]  ROM_DO;
    logic [3:0]  ROM_DI = '0;
    logic        ROM_OEB;
    logic        ROM_spi_mode;

    int total = 0;
    int bad = 0;

    qcpu_rom_fetch dut (
        .clk_i(clk_i), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .quad_sel(quad_sel), .fetch_data(fetch_data), .fetch_valid(fetch_valid),
        .busy(busy), .CS_ROM(CS_ROM), .SCLK_ROM(SCLK_ROM), .ROM_DO(ROM_DO),
        .ROM_DI(ROM_DI), .ROM_OEB(ROM_OEB), .ROM_spi_mode(ROM_spi_mode)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // flash contents: a few pinned bytes, a simple hash elsewhere
    function automatic logic [7:0] mem(input logic [15:0] a);
        if (a == 16'h0123) return 8'hA5;
        if (a == 16'h0040) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // flash model: acts on SCLK rising edges, seen at the falling clk edge
    int          m_cnt = 0;
    int          m_oeb_err = 0;
    logic        m_prev = 1'b0;
    logic        m_quad = 1'b0;
    logic [7:0]  m_cmd = '0;
    logic [23:0] m_addr = '0;
    logic [7:0]  m_b;
    logic [15:0] m_ta;
    int          m_j;

    always @(negedge clk_i) begin
        if (CS_ROM) begin
            m_cnt  = 0;
            m_quad = 1'b0;
        end else if (SCLK_ROM && !m_prev) begin
            m_cnt++;
            if (m_cnt <= 8) m_cmd = {m_cmd[6:0], ROM_DO[0]};
            if (m_cnt == 8) m_quad = (m_cmd == 8'hEB);
            if (!m_quad) begin
                if (ROM_OEB !== 1'b0) m_oeb_err++;
                if (m_cnt >= 9 && m_cnt <= 32) m_addr = {m_addr[22:0], ROM_DO[0]};
                if (m_cnt >= 33) begin
                    m_j  = m_cnt - 33;
                    m_ta = m_addr[15:0] + 16'(m_j / 8);
                    m_b  = mem(m_ta);
                    ROM_DI = {2'b00, m_b[7 - (m_j % 8)], 1'b0};
                end
            end else begin
                if (ROM_OEB !== ((m_cnt >= 17) ? 1'b1 : 1'b0)) m_oeb_err++;
                if (m_cnt >= 9 && m_cnt <= 14) m_addr = {m_addr[19:0], ROM_DO};
                if (m_cnt >= 21) begin
                    m_j  = m_cnt - 21;
                    m_ta = m_addr[15:0] + 16'(m_j / 2);
                    m_b  = mem(m_ta);
                    ROM_DI = (m_j % 2 == 0) ? m_b[7:4] : m_b[3:0];
                end
            end
        end
        m_prev = SCLK_ROM;
    end

    // One fetch; lat is the cycle (acceptance edge = 1) where fetch_valid is first seen.
    task automatic do_fetch(input string tag, input logic [15:0] a, input logic q, input int poke,
                            output int lat, output logic [7:0] d, output int cs_hi,
                            output logic spim);
        lat = -1; cs_hi = 0; d = '0; spim = 1'b0;
        m_oeb_err = 0;
        @(negedge clk_i);
        fetch_req = 1'b1; fetch_addr = a; quad_sel = q;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_i); #1;
            if (n == 1) begin
                fetch_req = 1'b0;
                check({tag, ".busy_start"}, busy, 1);
            end
            if (poke != 0 && n == poke) begin
                fetch_req = 1'b1; fetch_addr = 16'h0300;
            end
            if (poke != 0 && n == poke + 1) fetch_req = 1'b0;
            if (CS_ROM) cs_hi++;
            if (fetch_valid) begin
                lat = n; d = fetch_data; spim = ROM_spi_mode;
                check({tag, ".busy_fv"}, busy, 1);
                break;
            end
        end
    endtask

    task automatic fetch_chk(input string tag, input logic [15:0] a, input logic q,
                             input int exp_lat, input logic [7:0] exp_d, input int exp_cs,
                             input logic exp_spim, input int poke);
        int lat, cs_hi;
        logic [7:0] d;
        logic spim;
        do_fetch(tag, a, q, poke, lat, d, cs_hi, spim);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".data"}, d, exp_d);
        check({tag, ".cs_high_cycles"}, cs_hi, exp_cs);
        check({tag, ".spi_mode"}, spim, exp_spim);
        check({tag, ".oeb_errors"}, m_oeb_err, 0);
        @(posedge clk_i); #1;
        check({tag, ".fv_one_cycle"}, fetch_valid, 0);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".cs_hold"}, CS_ROM, 0);
        check({tag, ".data_held"}, fetch_data, exp_d);
    endtask

    int fv_seen;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.cs", CS_ROM, 1);
        check("rst.sclk", SCLK_ROM, 0);
        check("rst.do", ROM_DO, 0);
        check("rst.oeb", ROM_OEB, 1);
        check("rst.spi_mode", ROM_spi_mode, 1);
        check("rst.fv", fetch_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.data", fetch_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("idle.cs", CS_ROM, 1);

        fetch_chk("spi_0123", 16'h0123, 1'b0, 81, 8'hA5, 0, 1'b1, 0);
        check("spi_0123.cmd", m_cmd, 8'h03);
        check("spi_0123.addr", m_addr, 24'h000123);

        // non-sequential from HOLD, with an ignored request mid-fetch
        fetch_chk("spi_0010", 16'h0010, 1'b0, 83, 8'h4A, 2, 1'b1, 40);
        fetch_chk("seq_0011", 16'h0011, 1'b0, 17, 8'h4B, 0, 1'b1, 0);
        fetch_chk("spi_ffff", 16'hFFFF, 1'b0, 83, 8'h5A, 2, 1'b1, 0);
        m_cmd = '0;
        fetch_chk("wrap_0000", 16'h0000, 1'b0, 83, 8'h5A, 2, 1'b1, 0);
        check("wrap_0000.cmd", m_cmd, 8'h03);
        check("wrap_0000.addr", m_addr, 24'h000000);

        // HOLD timeout
        repeat (60) @(posedge clk_i);
        #1;
        check("hold60.cs", CS_ROM, 0);
        repeat (10) @(posedge clk_i);
        #1;
        check("hold70.cs", CS_ROM, 1);
        check("hold70.data", fetch_data, 8'h5A);
        fetch_chk("fresh_0200", 16'h0200, 1'b0, 81, 8'h58, 0, 1'b1, 0);

        // reset in the middle of a fetch
        @(negedge clk_i);
        fetch_req = 1'b1; fetch_addr = 16'h0077; quad_sel = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk_i); #1;
            if (n == 1) fetch_req = 1'b0;
        end
        check("abort.cs_before", CS_ROM, 0);
        check("abort.busy_before", busy, 1);
        rst_n = 1'b0;
        @(posedge clk_i); #1;
        check("abort.cs", CS_ROM, 1);
        check("abort.busy", busy, 0);
        check("abort.fv", fetch_valid, 0);
        check("abort.data", fetch_data, 0);
        rst_n = 1'b1;
        fv_seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk_i); #1;
            if (fetch_valid) fv_seen++;
        end
        check("abort.no_fv", fv_seen, 0);
        fetch_chk("after_rst_0077", 16'h0077, 1'b0, 81, 8'h2D, 0, 1'b1, 0);
        repeat (70) @(posedge clk_i);
        #1;
        check("idle2.cs", CS_ROM, 1);

`ifdef QCPU_ROM_QUAD_EN
        fetch_chk("quad_0040", 16'h0040, 1'b1, 45, 8'h3C, 0, 1'b0, 0);
        check("quad_0040.cmd", m_cmd, 8'hEB);
        check("quad_0040.addr", m_addr, 24'h000040);
        fetch_chk("quad_seq_0041", 16'h0041, 1'b1, 5, 8'h1B, 0, 1'b0, 0);
`else
        fetch_chk("qsel_ign_0040", 16'h0040, 1'b1, 81, 8'h3C, 0, 1'b1, 0);
        check("qsel_ign_0040.cmd", m_cmd, 8'h03);
        fetch_chk("qsel_ign_seq_0041", 16'h0041, 1'b1, 17, 8'h1B, 0, 1'b1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qcpu_rom_fetch.md
QCPU_ROM_FETCH -- requirements
Module: qcpu_rom_fetch

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low: ports clk_i and rst_n.
REQ-002 SHALL provide these ports:
- clk_i  in  1  clock
- rst_n  in  1  sync active-low reset
- fetch_req  in  1  byte fetch request
- fetch_addr  in  16  byte address
- quad_sel  in  1  1 = quad read, 0 = single-bit SPI read
- fetch_data  out  8  fetched byte
- fetch_valid  out  1  one-cycle pulse, fetch_data valid
- busy  out  1  request in progress
- CS_ROM  out  1  flash chip select, active low
- SCLK_ROM  out  1  flash clock
- ROM_DO  out  4  flash data out
- ROM_DI  in  4  flash data in
- ROM_OEB  out  1  0 = drive ROM_DO pins
- ROM_spi_mode  out  1  1 = single-bit mode (DO[0] out, DI[1] in)

Function
REQ-003 SHALL accept fetch_req only while busy=0; the cycle of acceptance captures fetch_addr and quad_sel; busy=1 from the next cycle until the fetch_valid cycle inclusive.
REQ-004 SHALL sequence states IDLE -> CMD -> ADDR -> [DUMMY] -> DATA -> HOLD, plus DESEL.
REQ-005 SHALL run SCLK_ROM at clk_i/2: each SCLK bit = low cycle (outputs updated), then high cycle (ROM_DI sampled at the end of that cycle), MSB first.
REQ-006 SPI mode: CMD 0x03 on DO[0] (8 SCLK); ADDR {8'h00, addr} on DO[0] (24 SCLK); DATA 8 bits from DI[1] (8 SCLK); ROM_spi_mode=1, ROM_OEB=0 throughout.
REQ-007 Quad mode: CMD 0xEB on DO[0] (8 SCLK, ROM_OEB=0); ADDR on DO[3:0] (6 SCLK); mode byte 0x00 (2 SCLK, ROM_OEB=0); dummy (4 SCLK, ROM_OEB=1); DATA from DI[3:0], high nibble first (2 SCLK, ROM_OEB=1); ROM_spi_mode=0.
REQ-008 SHALL drive fetch_valid for exactly one cycle, with fetch_data updated the same cycle; fetch_data holds until the next fetch_valid.
REQ-009 Latency from acceptance to fetch_valid: SPI fresh 81 cycles, quad fresh 45 cycles.
REQ-010 After DATA, SHALL enter HOLD: CS_ROM=0, SCLK_ROM=0, busy=0.
REQ-011 In HOLD, a request with addr == previous+1 (16-bit, no wrap) and unchanged quad_sel SHALL go directly to DATA: latency SPI 17, quad 5.
REQ-012 In HOLD, a non-sequential request (including 0xFFFF -> 0x0000 or a quad_sel change) SHALL enter DESEL: CS_ROM=1 for 2 cycles, then CMD; latency = fresh latency + 2.
REQ-013 In HOLD with no request for 64 consecutive cycles, SHALL return to IDLE with CS_ROM=1.
REQ-014 fetch_req asserted while busy=1 SHALL be ignored; no queuing.
REQ-015 In IDLE: CS_ROM=1, SCLK_ROM=0, ROM_DO=0, ROM_OEB=1.

Reset
REQ-016 With rst_n=0 at a clk_i edge: CS_ROM=1, SCLK_ROM=0, ROM_DO=0, ROM_OEB=1, ROM_spi_mode=1, fetch_valid=0, busy=0, fetch_data=0x00, state IDLE, hold counter 0.
REQ-017 Reset mid-transfer SHALL abort immediately with no fetch_valid; the first request after reset SHALL use the fresh sequence.

Configuration
REQ-018 Macro QCPU_ROM_QUAD_EN: when defined, quad mode per REQ-007; when undefined, quad_sel is ignored, ROM_spi_mode is constantly 1, all fetches use SPI timing, and the DUMMY logic is absent.

Verification
REQ-019 SPI read: quad_sel=0, addr 0x0123, flash model byte 0xA5 -> DO[0] shows 0x03, 0x000123; fetch_valid at +81 with fetch_data=0xA5.
REQ-020 Quad read (macro on): addr 0x0040, byte 0x3C -> ROM_OEB=1 from the dummy phase on; fetch_valid at +45 with 0x3C; ROM_spi_mode=0.
REQ-021 Sequential: SPI fetch at 0x0010, then 0x0011 in HOLD -> CS_ROM stays 0; second fetch_valid at +17.
REQ-022 Non-sequential/wrap: fetch at 0xFFFF, then 0x0000 -> CS_ROM=1 for 2 cycles, full CMD resent; fetch_valid at +83.
REQ-023 Reset at cycle 30 of an SPI fetch -> CS_ROM=1 and busy=0 next edge, no fetch_valid; HOLD idle for 64 cycles -> CS_ROM=1.
